// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data RAM behind valid/ready request and
// response channels, with a programmable number of wait states before each
// access. One transaction is in flight at a time.
//
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   req_valid/ready  request handshake; req_ready is high only in IDLE
//   req_write        1 = store, 0 = load
//   req_addr         byte address, word index = req_addr[AW+1:2]
//   req_wdata        store data
//   rsp_valid/ready  response handshake; response held until accepted
//   rsp_rdata        load data, or echo of the stored word
//   rsp_err          access error (only with DMEM_BOUNDS_CHECK_EN)
//   busy             high whenever the FSM is not in IDLE
//
// Optional feature macro: DMEM_BOUNDS_CHECK_EN
//   Defined: misaligned or out-of-range addresses produce rsp_err = 1,
//   rsp_rdata = 0 and no RAM write. Undefined: addresses alias, rsp_err = 0.
`timescale 1ns/1ps

module dmem_responder #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_INIT = (LATENCY > 0) ? CW'(LATENCY - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            cap_write;
  logic [AW-1:0]   cap_idx;
  logic [31:0]     cap_wdata;
  logic            cap_err;

  logic [31:0]     mem [DEPTH];

  logic            accept_c;
  logic            access_c;
  logic            req_err_c;
  logic            acc_write_c;
  logic [AW-1:0]   acc_idx_c;
  logic [31:0]     acc_wdata_c;
  logic            acc_err_c;
  logic [31:0]     resp_data_c;

  // Address legality of the live request
`ifdef DMEM_BOUNDS_CHECK_EN
  assign req_err_c = (req_addr[1:0] != 2'b00) || ((req_addr >> (AW + 2)) != 32'd0);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};
  assign req_err_c = 1'b0;
`endif

  assign accept_c = (state == S_IDLE) && req_valid && req_ready;

  // With zero wait states the access happens on the acceptance edge, so the
  // live request is used; otherwise the captured copy is.
  assign acc_write_c = (state == S_IDLE) ? req_write          : cap_write;
  assign acc_idx_c   = (state == S_IDLE) ? req_addr[AW+1:2]   : cap_idx;
  assign acc_wdata_c = (state == S_IDLE) ? req_wdata          : cap_wdata;
  assign acc_err_c   = (state == S_IDLE) ? req_err_c          : cap_err;

  assign access_c = (LATENCY == 0) ? accept_c
                                   : ((state == S_WAIT) && (cnt == '0));

  assign resp_data_c = acc_err_c   ? 32'd0 :
                       acc_write_c ? acc_wdata_c : mem[acc_idx_c];

  // Data array: not reset, written only on a legal committed store
  always_ff @(posedge clk) begin
    if (access_c && acc_write_c && !acc_err_c) begin
      mem[acc_idx_c] <= acc_wdata_c;
    end
  end

  // Transaction FSM with registered handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cap_write <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
      cap_err   <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (accept_c) begin
            cap_write <= req_write;
            cap_idx   <= req_addr[AW+1:2];
            cap_wdata <= req_wdata;
            cap_err   <= req_err_c;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= S_WAIT;
            cnt       <= CNT_INIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - CW'(1);
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      // Access edge: overrides the WAIT transition taken above
      if (access_c) begin
        state     <= S_RESP;
        rsp_valid <= 1'b1;
        rsp_rdata <= resp_data_c;
        rsp_err   <= acc_err_c;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: three instances (LATENCY 2, 0, 4) driven by a
// table of directed transactions plus hand sequences for backpressure and
// reset during WAIT / RESP.
`timescale 1ns/1ps

module tb_dmem_responder;

  logic        clk;
  logic        reset     [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_write [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];
  logic        busy      [3];

  int n_checks = 0;
  int n_fail   = 0;

  dmem_responder #(.DEPTH(64), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0]));

  dmem_responder #(.DEPTH(64), .LATENCY(0)) u_dut_l0 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1]));

  dmem_responder #(.DEPTH(64), .LATENCY(4)) u_dut_l4 (
    .clk(clk), .reset(reset[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
    .rsp_err(rsp_err[2]), .busy(busy[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          d;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 0 : 4;
  endfunction

  task automatic add_vec(input int d, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err);
    vec_t v;
    v.d = d; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request; returns at the first RESP cycle (or after the
  // handshake if rsp_ready is high). lat counts cycles after acceptance.
  task automatic do_txn(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat, output time acc_t);
    int  n;
    bit  ok;
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (req_ready[d]) ok = 1'b1;
      @(posedge clk);
      n++;
    end
    acc_t = $time;
    #1 req_valid[d] = 1'b0;
    if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
    lat = 1;
    @(negedge clk);
    while (!rsp_valid[d] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    rdata = rsp_rdata[d];
    err   = rsp_err[d];
    if (rsp_ready[d]) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  time         t_acc;
  time         t_prev;
  logic [31:0] exp64;

  initial begin
    for (int k = 0; k < 3; k++) begin
      reset[k] = 1'b1; req_valid[k] = 1'b0; req_write[k] = 1'b0;
      req_addr[k] = '0; req_wdata[k] = '0; rsp_ready[k] = 1'b1;
    end

    // Directed transaction table
    add_vec(0, 1'b1, 32'h64, 32'h7,        32'h7,        1'b0);
    add_vec(0, 1'b0, 32'h64, 32'h0,        32'h7,        1'b0);
    add_vec(0, 1'b1, 32'h60, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    add_vec(0, 1'b1, 32'h00, 32'h11111111, 32'h11111111, 1'b0);
`ifdef DMEM_BOUNDS_CHECK_EN
    add_vec(0, 1'b1, 32'h100, 32'h1,       32'h0,        1'b1);
    add_vec(0, 1'b0, 32'h00,  32'h0,       32'h11111111, 1'b0);
    add_vec(0, 1'b1, 32'h66,  32'h22,      32'h0,        1'b1);
    add_vec(0, 1'b0, 32'h64,  32'h0,       32'h7,        1'b0);
    exp64 = 32'h7;
`else
    add_vec(0, 1'b1, 32'h100, 32'h1,       32'h1,        1'b0);
    add_vec(0, 1'b0, 32'h00,  32'h0,       32'h1,        1'b0);
    add_vec(0, 1'b1, 32'h66,  32'h22,      32'h22,       1'b0);
    add_vec(0, 1'b0, 32'h64,  32'h0,       32'h22,       1'b0);
    exp64 = 32'h22;
`endif
    add_vec(1, 1'b1, 32'h00, 32'h1, 32'h1, 1'b0);
    add_vec(1, 1'b1, 32'h04, 32'h2, 32'h2, 1'b0);
    add_vec(1, 1'b1, 32'h08, 32'h3, 32'h3, 1'b0);
    add_vec(1, 1'b0, 32'h00, 32'h0, 32'h1, 1'b0);
    add_vec(1, 1'b0, 32'h04, 32'h0, 32'h2, 1'b0);
    add_vec(1, 1'b0, 32'h08, 32'h0, 32'h3, 1'b0);
    add_vec(2, 1'b1, 32'h10, 32'h0, 32'h0, 1'b0);
    add_vec(2, 1'b1, 32'h14, 32'h0, 32'h0, 1'b0);

    // Reset and release
    #10;
    chk("ready_in_reset", 32'(req_ready[0]), 32'd0);
    #12;
    for (int k = 0; k < 3; k++) reset[k] = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready[0]), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst_busy",      32'(busy[0]),      32'd0);
    chk("rst_rsp_rdata", rsp_rdata[0],      32'd0);

    // Table: data, error flag, latency, and acceptance spacing
    t_prev = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      do_txn(tbl[i].d, tbl[i].wr, tbl[i].addr, tbl[i].wdata, rd, er, lat, t_acc);
      chk($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rdata);
      chk($sformatf("v%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(lat_of(tbl[i].d) + 1));
      if (i > 0 && tbl[i].d == tbl[i-1].d)
        chk($sformatf("v%0d_spacing", i), 32'((t_acc - t_prev) / 10),
            32'(lat_of(tbl[i].d) + 2));
      t_prev = t_acc;
    end

    // Backpressure: response held while request inputs wiggle
    rsp_ready[0] = 1'b0;
    do_txn(0, 1'b0, 32'h60, 32'h0, rd, er, lat, t_acc);
    chk("bp_first_rdata", rd, 32'hDEADBEEF);
    chk("bp_latency", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      req_valid[0] = (i % 2 == 0);
      req_write[0] = 1'b1;
      req_addr[0]  = 32'h64;
      req_wdata[0] = 32'h00000BAD;
      @(negedge clk);
      chk($sformatf("bp%0d_rsp_valid", i), 32'(rsp_valid[0]), 32'd1);
      chk($sformatf("bp%0d_rdata", i), rsp_rdata[0], 32'hDEADBEEF);
      chk($sformatf("bp%0d_req_ready", i), 32'(req_ready[0]), 32'd0);
    end
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    req_write[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(rsp_valid[0]), 32'd1);
    @(negedge clk);
    chk("bp_idle_busy",  32'(busy[0]),      32'd0);
    chk("bp_idle_valid", 32'(rsp_valid[0]), 32'd0);
    chk("bp_idle_ready", 32'(req_ready[0]), 32'd1);
    do_txn(0, 1'b0, 32'h64, 32'h0, rd, er, lat, t_acc);
    chk("bp_no_stray_write", rd, exp64);

    // Reset while a store waits: store discarded
    req_valid[2] = 1'b1; req_write[2] = 1'b1;
    req_addr[2] = 32'h10; req_wdata[2] = 32'hA5A5A5A5;
    @(negedge clk);
    chk("l4_ready", 32'(req_ready[2]), 32'd1);
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("l4_busy_in_wait", 32'(busy[2]), 32'd1);
    reset[2] = 1'b1;
    #1;
    chk("wrst_rsp_valid", 32'(rsp_valid[2]), 32'd0);
    chk("wrst_busy",      32'(busy[2]),      32'd0);
    @(negedge clk);
    #2 reset[2] = 1'b0;
    do_txn(2, 1'b0, 32'h10, 32'h0, rd, er, lat, t_acc);
    chk("wrst_ram_unchanged", rd, 32'h0);
    chk("wrst_latency", 32'(lat), 32'd5);

    // Reset while a response is pending: committed store persists
    rsp_ready[2] = 1'b0;
    do_txn(2, 1'b1, 32'h14, 32'h5A5A5A5A, rd, er, lat, t_acc);
    chk("rrst_echo", rd, 32'h5A5A5A5A);
    #2 reset[2] = 1'b1;
    #1;
    chk("rrst_rsp_valid", 32'(rsp_valid[2]), 32'd0);
    chk("rrst_req_ready", 32'(req_ready[2]), 32'd0);
    chk("rrst_rsp_rdata", rsp_rdata[2],      32'd0);
    @(negedge clk);
    #2 reset[2] = 1'b0;
    rsp_ready[2] = 1'b1;
    do_txn(2, 1'b0, 32'h14, 32'h0, rd, er, lat, t_acc);
    chk("rrst_ram_kept", rd, 32'h5A5A5A5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
